// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC-source encodings, bubble word, fetch states
// and the IF/ID payload.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic {
    FS_WAIT = 1'b0,
    FS_HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] p);
    return p + XLEN'(4);
  endfunction

endpackage

// File: rtl/pipeir.sv
// IF/ID pipeline register: load a fetched instruction with its pc+4, or
// replace the instruction with a bubble while keeping dpc4.
module pipeir
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            load,
  input  logic            bubble,
  input  ifid_t           d,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] dpc4
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inst <= NOP_INST;
      dpc4 <= '0;
    end else if (bubble) begin
      inst <= NOP_INST;
    end else if (load) begin
      inst <= d.inst;
      dpc4 <= d.pc4;
    end
  end

endmodule

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection, single-outstanding
// memory request FSM, hold buffer for stalled responses, deferred redirects.
module pipeif_fetch
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = NOP
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] jpc,
  input  logic [XLEN-1:0] rpc,
  input  logic            wpcir,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] dpc4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] ptgt_q, ptgt_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            ir_load;
  logic            ir_bubble;
  ifid_t           ir_d;

  // Redirect is only honoured when decode is advancing.
  always_comb begin
    redirect = wpcir && (pcsource != PC_SEQ);
    unique case (pcsource)
      PC_BR:   target = bpc;
      PC_JR:   target = rpc;
      PC_J:    target = jpc;
      default: target = pc_plus4(pc_q);
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= FS_WAIT;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INST;
      pend_q  <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
    end
  end

  // Next-state and IF/ID control; the fetched word after a taken transfer is killed.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    pend_d    = pend_q;
    ptgt_d    = ptgt_q;
    ir_load   = 1'b0;
    ir_bubble = 1'b0;
    ir_d.inst = imem_rdata;
    ir_d.pc4  = pc_plus4(pc_q);

    case (state_q)
      FS_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            ir_bubble = 1'b1;
            pc_d      = target;
            pend_d    = 1'b0;
          end else if (pend_q) begin
            ir_bubble = 1'b1;
            pc_d      = ptgt_q;
            pend_d    = 1'b0;
          end else if (wpcir) begin
            ir_load = 1'b1;
            pc_d    = pc_plus4(pc_q);
          end else begin
            buf_d   = imem_rdata;
            state_d = FS_HOLD;
          end
        end else begin
          ir_bubble = wpcir;
          // Address must stay stable until the response, so defer the redirect.
          if (redirect) begin
            pend_d = 1'b1;
            ptgt_d = target;
          end
        end
      end
      FS_HOLD: begin
        ir_d.inst = buf_q;
        if (wpcir) begin
          state_d = FS_WAIT;
          if (redirect) begin
            ir_bubble = 1'b1;
            pc_d      = target;
          end else begin
            ir_load = 1'b1;
            pc_d    = pc_plus4(pc_q);
          end
        end
      end
    endcase
  end

  pipeir #(
    .NOP_INST(NOP_INST)
  ) u_pipeir (
    .clock  (clock),
    .resetn (resetn),
    .load   (ir_load),
    .bubble (ir_bubble),
    .d      (ir_d),
    .inst   (inst),
    .dpc4   (dpc4)
  );

  assign imem_req  = (state_q == FS_WAIT);
  assign imem_addr = pc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_pipeif_fetch.sv
// Bench for pipeif_fetch: directed scenarios then random stimulus with a
// variable-latency memory, checked against a rule-level fetch model.
module tb_pipeif_fetch;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] NOPW = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, jpc = '0, rpc = '0;
  logic        wpcir = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc, inst, dpc4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_inst, m_dpc4, m_buf, m_ptgt;
  bit          m_hold, m_pend;

  pipeif_fetch dut (
    .clock       (clock),
    .resetn      (resetn),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .jpc         (jpc),
    .rpc         (rpc),
    .wpcir       (wpcir),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .inst        (inst),
    .dpc4        (dpc4)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%08h exp=%08h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC0; m_inst = NOPW; m_dpc4 = '0; m_buf = '0; m_ptgt = '0;
    m_hold = 0; m_pend = 0;
  endtask

  // Apply one clock edge's worth of fetch rules to the model.
  task automatic model_step(input logic wp, input logic [1:0] ps, input logic rv,
                            input logic [31:0] rd);
    bit          redir;
    logic [31:0] tgt;
    redir = wp && (ps != 2'b00);
    tgt = (ps == 2'b01) ? bpc : (ps == 2'b10) ? rpc : jpc;
    if (!m_hold) begin
      if (rv) begin
        if (redir || m_pend) begin
          m_inst = NOPW;
          m_pc   = redir ? tgt : m_ptgt;
          m_pend = 0;
        end else if (wp) begin
          m_inst = rd;
          m_dpc4 = m_pc + 32'd4;
          m_pc   = m_pc + 32'd4;
        end else begin
          m_buf  = rd;
          m_hold = 1;
        end
      end else begin
        if (wp) m_inst = NOPW;
        if (redir) begin
          m_pend = 1;
          m_ptgt = tgt;
        end
      end
    end else if (wp) begin
      m_hold = 0;
      if (redir) begin
        m_inst = NOPW;
        m_pc   = tgt;
      end else begin
        m_inst = m_buf;
        m_dpc4 = m_pc + 32'd4;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    check32("pc", pc, m_pc);
    check32("imem_addr", imem_addr, m_pc);
    check32("imem_req", {31'b0, imem_req}, {31'b0, !m_hold});
    check32("inst", inst, m_inst);
    check32("dpc4", dpc4, m_dpc4);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input logic wp, input logic [1:0] ps, input logic rv,
                      input logic [31:0] rd);
    wpcir = wp; pcsource = ps; imem_rvalid = rv; imem_rdata = rd;
    model_step(wp, ps, rv, rd);
    @(posedge clock);
    #1;
    cyc++;
    check_all();
  endtask

  initial begin
    int  lat, cnt;
    bit  req_now;
    logic        wp, rv;
    logic [1:0]  ps;
    logic [31:0] rd;

    model_reset();
    #12 resetn = 1'b1;
    check_all();

    // Sequential zero-wait fetch
    step(1, 2'b00, 1, mem(32'h0));
    check32("seq_inst0", inst, 32'hA5A5_0000);
    step(1, 2'b00, 1, mem(32'h4));
    check32("seq_inst1", inst, 32'hA5A5_0004);
    check32("seq_dpc4", dpc4, 32'h8);

    // Stall on response at 0x8
    step(0, 2'b00, 1, mem(32'h8));
    check32("hold_req", {31'b0, imem_req}, 32'h0);
    repeat (3) step(0, 2'b00, 0, 32'hDEAD_BEEF);
    check32("hold_inst", inst, 32'hA5A5_0004);
    step(1, 2'b00, 0, 32'h0);
    check32("rel_inst", inst, 32'hA5A5_0008);
    check32("rel_dpc4", dpc4, 32'hC);
    check32("rel_addr", imem_addr, 32'hC);

    // Branch with same-cycle response
    bpc = 32'h40;
    step(1, 2'b01, 1, mem(32'hC));
    check32("br_inst", inst, NOPW);
    check32("br_addr", imem_addr, 32'h40);
    step(1, 2'b00, 1, mem(32'h40));
    check32("br_tgt_inst", inst, 32'hA5A5_0040);
    check32("br_tgt_dpc4", dpc4, 32'h44);

    // Jump during a 3-cycle memory latency
    jpc = 32'h100;
    step(1, 2'b11, 0, 32'h0);
    check32("j_addr_held", imem_addr, 32'h44);
    step(1, 2'b00, 0, 32'h0);
    step(1, 2'b00, 1, mem(32'h44));
    check32("j_inst", inst, NOPW);
    check32("j_addr", imem_addr, 32'h100);

    // jr releasing HOLD kills buffered word
    step(0, 2'b00, 1, mem(32'h100));
    step(0, 2'b00, 0, 32'h0);
    rpc = 32'h200;
    step(1, 2'b10, 0, 32'h0);
    check32("jr_inst", inst, NOPW);
    check32("jr_addr", imem_addr, 32'h200);

    // Wrap at top of address space
    jpc = 32'hFFFF_FFFC;
    step(1, 2'b11, 1, mem(32'h200));
    step(1, 2'b00, 1, mem(32'hFFFF_FFFC));
    check32("wrap_pc", pc, 32'h0);
    check32("wrap_dpc4", dpc4, 32'h0);

    // Asynchronous reset while a request is outstanding
    step(1, 2'b00, 0, 32'h0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check32("rst_pc", pc, RPC0);
    check32("rst_inst", inst, NOPW);
    check32("rst_dpc4", dpc4, 32'h0);
    #2 resetn = 1'b1;

    // Random traffic with variable-latency memory
    cnt = 0;
    lat = $urandom_range(0, 3);
    for (int i = 0; i < 800; i++) begin
      wp = ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bpc = $urandom; jpc = $urandom; rpc = $urandom;
      req_now = !m_hold;
      if (req_now) begin
        rv = (cnt >= lat);
        rd = rv ? mem(m_pc) : $urandom;
      end else begin
        rv = 1'($urandom_range(0, 1));
        rd = $urandom;
      end
      step(wp, ps, rv, rd);
      if (req_now) begin
        if (rv) begin
          cnt = 0;
          lat = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeif_fetch.md
Name: pipeif_fetch

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU: owns the PC, drives the instruction-memory request port, and loads the IF/ID pipeline register.
- Consumes the decode stage's redirect outputs (pcsource, bpc, jpc, jr target) and its PC/IR write enable (wpcir).
- Produces inst/dpc4 for decode.
- Tolerates variable-latency instruction memory; one request outstanding at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INST, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
pcsource  in  2  from decode: 00 pc+4, 01 bpc (beq/bne), 10 rpc (jr), 11 jpc (j/jal)
bpc  in  32  branch target from decode
jpc  in  32  jump target from decode
rpc  in  32  jr target (decode's forwarded rs value)
wpcir  in  1  1 = pipeline may advance; 0 = load-use stall, hold PC and IF/ID
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (current pc)
imem_rvalid  in  1  response valid; sampled while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_rvalid
pc  out  32  current fetch PC
inst  out  32  IF/ID instruction register
dpc4  out  32  IF/ID pc+4 register

Behaviour:
- States: WAIT (request outstanding), HOLD (response buffered, decode stalled).
- Reset: pc=RESET_PC, inst=NOP_INST, dpc4=0, state=WAIT, redirect-pending=0. imem_req=(state==WAIT), so it is 1 on the first cycle after reset release. Memory ignores imem_req while resetn=0.
- Memory protocol: imem_addr=pc, held stable while imem_req=1 until the edge where imem_rvalid=1. Zero-wait response (rvalid in the request's first cycle) is legal. Fetch rate is one instruction per cycle with zero-wait memory.
- Redirect: redirect = wpcir & (pcsource!=00); target is selected by pcsource. A redirect while wpcir=0 is ignored.
- WAIT, rvalid=1:
  - If a redirect is pending or arriving this cycle: data is discarded, inst<=NOP_INST, pc<=target (or the latched target), pending cleared; stay in WAIT. A live redirect takes priority over a latched one.
  - Else if wpcir=1: inst<=imem_rdata, dpc4<=pc+4, pc<=pc+4; stay in WAIT.
  - Else (wpcir=0): rdata goes to the hold buffer, pc unchanged, go to HOLD. inst/dpc4 are held.
- WAIT, rvalid=0:
  - If wpcir=1: inst<=NOP_INST (bubble); dpc4 unchanged.
  - If redirect: latch target into redirect-pending; pc and imem_addr are unchanged until the response is consumed.
  - If wpcir=0: IF/ID holds.
- HOLD: imem_req=0.
  - wpcir=0: hold everything.
  - wpcir=1 with no redirect: inst<=buffer, dpc4<=pc+4, pc<=pc+4, go to WAIT.
  - wpcir=1 with redirect: buffer killed, inst<=NOP_INST, pc<=target, go to WAIT.
- Kill semantics: the instruction fetched after a taken control transfer never reaches decode (no delay slot). This matches decode's bubble on pcsource!=00.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Targets are used unmodified (low 2 bits are not forced).
- Async reset mid-transaction: all state clears immediately, and the outstanding response is lost.

Decomposition:
- Shared package pipe_pkg:
  - pcsource encodings (PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_J=2'b11)
  - NOP constant
  - fetch state encoding (WAIT/HOLD)
- Sub-module pipeir: IF/ID register with load enable and bubble-insert input (async active-low reset to NOP/0). The top level holds the PC register, next-PC mux, FSM, hold buffer and redirect-pending latch.

Test Plan:
- Sequential fetch: reset, zero-wait memory returning rdata=addr^32'hA5A5_0000, wpcir=1, pcsource=00 -> imem_addr 0,4,8; inst 32'hA5A5_0000, 32'hA5A5_0004; dpc4 4,8,...
- Stall: wpcir=0 on the cycle rvalid returns addr 0x8 -> HOLD, imem_req=0, inst/dpc4 frozen for 3 cycles; wpcir=1 -> inst=32'hA5A5_0008, dpc4=0xC, next imem_addr=0xC.
- Branch: pcsource=01, bpc=0x40 with a same-cycle rvalid -> inst=NOP, next imem_addr=0x40, then inst=32'hA5A5_0040, dpc4=0x44.
- Redirect during 3-cycle memory latency: pcsource=11, jpc=0x100 in cycle 1 of the wait -> imem_addr holds the old pc until rvalid, data discarded, next imem_addr=0x100.
- jr while HOLD released: pcsource=10, rpc=0x200, wpcir=1 -> buffered instruction killed, inst=NOP, imem_addr=0x200.
- Reset mid-wait, and wrap: pull resetn low while imem_req=1 -> pc=RESET_PC, inst=0, dpc4=0 without a clock edge. Separately, pc=0xFFFF_FFFC advancing sequentially -> dpc4=0, pc=0.
